// File: rtl/anita4_trig_pkg.sv
// anita4_trig_pkg: shared state encoding and default parameters for the L/R coincidence trigger
package anita4_trig_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OPEN  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;
  localparam int DEF_WINDOW  = 4;
  localparam int DEF_CLR_LEN = 2;
  localparam int DEF_SCAL_W  = 16;
endpackage

// File: rtl/anita4_pol_win_fsm.sv
// anita4_pol_win_fsm: per-polarisation hit window, latch clear pulse and re-arm wait
module anita4_pol_win_fsm
  import anita4_trig_pkg::*;
#(
  parameter int WINDOW  = DEF_WINDOW,
  parameter int CLR_LEN = DEF_CLR_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  input  logic enable_i,
  input  logic other_open_i,
  output logic open_o,
  output logic hit_o,
  output logic single_o,
  output logic clr_o
);
  logic [1:0] state_q, state_d;
  logic [3:0] win_q, win_d;
  logic [2:0] clr_cnt_q, clr_cnt_d;
  logic       single_q, clr_q, close;
  assign open_o   = state_q == ST_OPEN;
  assign hit_o    = state_q == ST_IDLE && sync_i && enable_i;
  // coincidence outranks window expiry
  assign close    = open_o && (other_open_i || win_q == 4'd0);
  assign single_o = single_q;
  assign clr_o    = clr_q;
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: if (sync_i) begin
        state_d   = enable_i ? ST_OPEN : ST_CLEAR;
        win_d     = 4'(WINDOW - 1);
        clr_cnt_d = 3'(CLR_LEN - 1);
      end
      ST_OPEN: begin
        win_d     = win_q - 4'd1;
        state_d   = close ? ST_CLEAR : ST_OPEN;
        clr_cnt_d = 3'(CLR_LEN - 1);
      end
      ST_CLEAR: begin
        state_d   = clr_cnt_q == 3'd0 ? ST_WAIT : ST_CLEAR;
        clr_cnt_d = clr_cnt_q - 3'd1;
      end
      default: state_d = sync_i ? ST_WAIT : ST_IDLE;
    endcase
  end
  // reset parks in WAIT with CLR high so the latch stays cleared until re-armed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT;
      win_q     <= '0;
      clr_cnt_q <= '0;
      single_q  <= 1'b0;
      clr_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      clr_cnt_q <= clr_cnt_d;
      single_q  <= close && !other_open_i;
      clr_q     <= state_d == ST_CLEAR;
    end
  end
endmodule

// File: rtl/anita4_lr_coinc_ctrl.sv
// anita4_lr_coinc_ctrl: L+R coincidence within a window, latch clears, saturating scalers with snapshot
module anita4_lr_coinc_ctrl
  import anita4_trig_pkg::*;
#(
  parameter int WINDOW  = DEF_WINDOW,
  parameter int CLR_LEN = DEF_CLR_LEN,
  parameter int SCAL_W  = DEF_SCAL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        l_sync_i,
  input  logic [2:0]        r_sync_i,
  input  logic              enable_i,
  input  logic              scal_latch_i,
  output logic              l_clr_o,
  output logic              r_clr_o,
  output logic              coinc_o,
  output logic              l_single_o,
  output logic              r_single_o,
  output logic              scal_valid_o,
  output logic [SCAL_W-1:0] l_scal_o,
  output logic [SCAL_W-1:0] r_scal_o,
  output logic [SCAL_W-1:0] c_scal_o
);
  logic                   l_open, r_open, l_hit, r_hit;
  logic                   coinc_q, scal_valid_q, unused_sync;
  logic [2:0]             evt;
  logic [2:0][SCAL_W-1:0] cnt_q, cnt_d, snap_q;
  // only the second synchroniser stage is safe to use
  assign unused_sync = ^{l_sync_i[2], l_sync_i[0], r_sync_i[2], r_sync_i[0]};
  anita4_pol_win_fsm #(.WINDOW(WINDOW), .CLR_LEN(CLR_LEN)) u_l (
    .clk(clk), .rst_n(rst_n), .sync_i(l_sync_i[1]), .enable_i(enable_i), .other_open_i(r_open),
    .open_o(l_open), .hit_o(l_hit), .single_o(l_single_o), .clr_o(l_clr_o)
  );
  anita4_pol_win_fsm #(.WINDOW(WINDOW), .CLR_LEN(CLR_LEN)) u_r (
    .clk(clk), .rst_n(rst_n), .sync_i(r_sync_i[1]), .enable_i(enable_i), .other_open_i(l_open),
    .open_o(r_open), .hit_o(r_hit), .single_o(r_single_o), .clr_o(r_clr_o)
  );
  assign evt = {l_open & r_open, r_hit, l_hit};
  // a snapshot edge restarts each counter at that edge's own event
  always_comb begin
    for (int k = 0; k < 3; k++)
      cnt_d[k] = scal_latch_i ? SCAL_W'(evt[k]) : cnt_q[k] + SCAL_W'(evt[k] & ~&cnt_q[k]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coinc_q      <= 1'b0;
      scal_valid_q <= 1'b0;
      cnt_q        <= '0;
      snap_q       <= '0;
    end else begin
      coinc_q      <= evt[2];
      scal_valid_q <= scal_latch_i;
      cnt_q        <= cnt_d;
      if (scal_latch_i) snap_q <= cnt_q;
    end
  end
  assign coinc_o      = coinc_q;
  assign scal_valid_o = scal_valid_q;
  assign l_scal_o     = snap_q[0];
  assign r_scal_o     = snap_q[1];
  assign c_scal_o     = snap_q[2];
endmodule

// File: tb/tb_anita4_lr_coinc_ctrl.sv
// tb_anita4_lr_coinc_ctrl: directed window/scaler scenarios plus random traffic against an edge-timeline model
module tb_anita4_lr_coinc_ctrl;
  localparam int W = 4, CL = 2, SW = 4, SMAX = 15;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic [2:0]    l_sync = '0, r_sync = '0;
  logic          enable = 1'b1, scal_latch = 1'b0;
  logic          l_clr, r_clr, coinc, l_single, r_single, scal_valid;
  logic [SW-1:0] l_scal, r_scal, c_scal;
  anita4_lr_coinc_ctrl #(.WINDOW(W), .CLR_LEN(CL), .SCAL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .l_sync_i(l_sync), .r_sync_i(r_sync), .enable_i(enable),
    .scal_latch_i(scal_latch), .l_clr_o(l_clr), .r_clr_o(r_clr), .coinc_o(coinc),
    .l_single_o(l_single), .r_single_o(r_single), .scal_valid_o(scal_valid),
    .l_scal_o(l_scal), .r_scal_o(r_scal), .c_scal_o(c_scal)
  );
  always #5 clk = ~clk;
  int pass_cnt = 0, total_cnt = 0;
  task automatic check(string name, int got, int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask
  // model: each polarisation is described by the edge its window opened, the last edge
  // its clear is high after, and whether it is armed for a new hit
  int n = 0;
  int open_at[2], clr_last[2], live[3], snap[3];
  bit idle[2], e_sing[2], e_clr[2];
  bit e_coinc, e_valid, chk_en = 0;
  function automatic void reset_model();
    for (int p = 0; p < 2; p++) begin
      open_at[p] = -1; clr_last[p] = -10; idle[p] = 0; e_sing[p] = 0; e_clr[p] = 1;
    end
    for (int k = 0; k < 3; k++) begin live[k] = 0; snap[k] = 0; end
    e_coinc = 0; e_valid = 0;
  endfunction
  function automatic void model_edge();
    bit s[2], ev[3], both;
    s[0] = l_sync[1]; s[1] = r_sync[1];
    both = open_at[0] >= 0 && open_at[1] >= 0;
    ev[0] = 0; ev[1] = 0; ev[2] = both;
    for (int p = 0; p < 2; p++) begin
      e_sing[p] = 0;
      if (open_at[p] >= 0) begin
        if (both || n == open_at[p] + W) begin
          e_sing[p] = !both; open_at[p] = -1; clr_last[p] = n + CL - 1;
        end
      end else if (idle[p]) begin
        if (s[p]) begin
          idle[p] = 0;
          if (enable) begin open_at[p] = n; ev[p] = 1; end
          else clr_last[p] = n + CL - 1;
        end
      end else if (n > clr_last[p] + 1 && !s[p]) idle[p] = 1;
      e_clr[p] = n <= clr_last[p];
    end
    e_coinc = both;
    e_valid = scal_latch;
    for (int k = 0; k < 3; k++) begin
      if (scal_latch) begin snap[k] = live[k]; live[k] = ev[k]; end
      else live[k] += ev[k];
    end
  endfunction
  function automatic int sat(int v);
    return v > SMAX ? SMAX : v;
  endfunction
  always @(posedge clk) begin
    n++;
    if (!rst_n) reset_model();
    else model_edge();
  end
  always @(negedge clk) if (chk_en) begin
    check("coinc", coinc, e_coinc);
    check("l_single", l_single, e_sing[0]);
    check("r_single", r_single, e_sing[1]);
    check("l_clr", l_clr, e_clr[0]);
    check("r_clr", r_clr, e_clr[1]);
    check("scal_valid", scal_valid, e_valid);
    check("l_scal", l_scal, sat(snap[0]));
    check("r_scal", r_scal, sat(snap[1]));
    check("c_scal", c_scal, sat(snap[2]));
  end
  task automatic tick(int k = 1);
    repeat (k) begin @(posedge clk); @(negedge clk); end
  endtask
  task automatic snapshot(string tag, int l, int r, int c);
    scal_latch = 1; tick(); scal_latch = 0;
    check({tag, "_valid"}, scal_valid, 1);
    check({tag, "_lscal"}, l_scal, l);
    check({tag, "_rscal"}, r_scal, r);
    check({tag, "_cscal"}, c_scal, c);
  endtask
  task automatic async_reset(string tag);
    #2 rst_n = 0;
    #1;
    check({tag, "_lclr"}, l_clr, 1);
    check({tag, "_rclr"}, r_clr, 1);
    check({tag, "_coinc"}, coinc, 0);
    check({tag, "_lsingle"}, l_single, 0);
    check({tag, "_rsingle"}, r_single, 0);
    check({tag, "_valid"}, scal_valid, 0);
    check({tag, "_lscal"}, l_scal, 0);
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
  endtask
  initial begin
    reset_model();
    @(posedge clk); @(negedge clk);
    chk_en = 1;
    check("rst_lclr", l_clr, 1);
    check("rst_coinc", coinc, 0);
    check("rst_cscal", c_scal, 0);
    rst_n = 1;
    tick();
    check("release_lclr", l_clr, 0);
    check("release_rclr", r_clr, 0);
    // lone left hit
    l_sync = 3'b010; tick(); l_sync = 3'b000;
    tick(3); check("lone_early", l_single, 0);
    tick();  check("lone_single", l_single, 1); check("lone_clr0", l_clr, 1);
    tick();  check("lone_clr1", l_clr, 1); check("lone_single_off", l_single, 0);
    tick();  check("lone_clr_off", l_clr, 0);
    tick();
    snapshot("lone", 1, 0, 0);
    // R two edges after L
    l_sync = 3'b010; tick(); l_sync = 0; tick();
    r_sync = 3'b010; tick(); r_sync = 0; tick();
    check("co_coinc", coinc, 1); check("co_lclr", l_clr, 1); check("co_rclr", r_clr, 1);
    check("co_lsingle", l_single, 0);
    tick(); check("co_coinc_off", coinc, 0); check("co_clr_hold", r_clr, 1);
    tick(4);
    snapshot("co", 1, 1, 1);
    // R on the last window edge
    l_sync = 3'b010; tick(); l_sync = 0; tick(2);
    r_sync = 3'b010; tick(); r_sync = 0; tick();
    check("last_coinc", coinc, 1); check("last_lsingle", l_single, 0);
    tick(5);
    snapshot("last", 1, 1, 1);
    // R one edge too late
    l_sync = 3'b010; tick(); l_sync = 0; tick(3);
    r_sync = 3'b010; tick(); r_sync = 0;
    check("late_lsingle", l_single, 1); check("late_coinc", coinc, 0);
    tick(3); check("late_r_early", r_single, 0);
    tick();  check("late_rsingle", r_single, 1);
    tick(4);
    snapshot("late", 1, 1, 0);
    // simultaneous entry
    l_sync = 3'b010; r_sync = 3'b010; tick(); l_sync = 0; r_sync = 0;
    tick(); check("sim_coinc", coinc, 1); check("sim_rsingle", r_single, 0);
    tick(6);
    snapshot("sim", 1, 1, 1);
    // stuck latch
    l_sync = 3'b111; tick(50);
    check("stuck_clr", l_clr, 0);
    l_sync = 0; tick(2);
    snapshot("stuck", 1, 0, 0);
    // disabled hit
    enable = 0; r_sync = 3'b010; tick(); r_sync = 0; enable = 1;
    check("dis_clr0", r_clr, 1);
    tick(); check("dis_clr1", r_clr, 1);
    tick(); check("dis_clr_off", r_clr, 0);
    tick(3);
    snapshot("dis", 0, 0, 0);
    // saturation
    repeat (20) begin l_sync = 3'b010; tick(); l_sync = 0; tick(7); end
    snapshot("sat", SMAX, 0, 0);
    // snapshot on the same edge as a hit
    l_sync = 3'b010; tick(); l_sync = 0; tick(7);
    l_sync = 3'b010; scal_latch = 1; tick(); l_sync = 0; scal_latch = 0;
    check("same_old", l_scal, 1);
    tick(7);
    snapshot("same_new", 1, 0, 0);
    // reset while the window is open
    l_sync = 3'b010; tick(); l_sync = 0; tick();
    async_reset("midrst");
    tick(8);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      l_sync = {1'($urandom), 1'($urandom_range(0, 9) < 3), 1'($urandom)};
      r_sync = {1'($urandom), 1'($urandom_range(0, 9) < 3), 1'($urandom)};
      enable = $urandom_range(0, 15) != 0;
      scal_latch = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
      tick();
    end
    l_sync = 0; r_sync = 0; enable = 1; scal_latch = 0;
    tick(10);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/anita4_lr_coinc_ctrl.md
# anita4_lr_coinc_ctrl

Consumes synchronised single-polarisation trigger chains for the left- and right-circular channels of one antenna and forms an L+R coincidence within a programmable window. Generates the clear pulses that re-arm each falling-edge trigger latch. Emits single and coincidence pulses to the L1 logic and keeps saturating scalers for housekeeping readout. Sits directly downstream of the per-polarisation trigger synchroniser; its CLR outputs drive that synchroniser's CLR input.

## Interface
- WINDOW, 4: coincidence window in CLK cycles (1..15)
- CLR_LEN, 2: clear pulse width in CLK cycles (1..7)
- SCAL_W, 16: scaler width
---
- CLK  in  1  trigger-domain clock
- RST_N  in  1  asynchronous, active-low reset
- L_SYNC  in  3  left-pol synchroniser chain; only bit [1] is used (bit [0] is metastable-exposed)
- R_SYNC  in  3  right-pol chain, same use
- ENABLE  in  1  0 = hits are cleared but not counted or reported
- L_CLR  out  1  clear to left latch/synchroniser
- R_CLR  out  1  clear to right latch/synchroniser
- COINC  out  1  one-cycle L+R coincidence pulse
- L_SINGLE  out  1  one-cycle pulse: left hit, window expired without R
- R_SINGLE  out  1  one-cycle pulse: same for right
- SCAL_LATCH  in  1  snapshot request; level sampled per cycle
- SCAL_VALID  out  1  one-cycle pulse: snapshot outputs updated
- L_SCAL, R_SCAL, C_SCAL  out  SCAL_W  snapshot of left-hit, right-hit and coincidence counts

## Operation
- One identical FSM per polarisation: IDLE, OPEN, CLEAR, WAIT.
- IDLE: if SYNC[1]=1 and ENABLE=1 -> OPEN. On that transition, load win_cnt=WINDOW-1 and increment the hit scaler. If SYNC[1]=1 and ENABLE=0 -> CLEAR, with no count and no pulse.
- OPEN: win_cnt decrements each cycle.
  - If both FSMs are in OPEN -> both go to CLEAR and COINC=1 on the same edge. Increment the C scaler.
  - Otherwise, if win_cnt=0 -> CLEAR and pulse xSINGLE.
  - Coincidence takes priority over expiry on the same cycle.
- CLEAR: xCLR=1 for exactly CLR_LEN cycles -> WAIT.
- WAIT: stays until SYNC[1]=0 -> IDLE. This guarantees that a latch held high is never double-counted.
- Scalers saturate at all-ones; they never wrap.
- SCAL_LATCH=1 at an edge:
  - Copy live counters to the snapshot outputs and pulse SCAL_VALID.
  - Reset live counters to 0, plus any event on that same edge, so no event is lost or double-counted.
- SCAL_LATCH held high snapshots every cycle.

## Timing
- Reset (RST_N=0, asynchronous):
  - Both FSMs go to WAIT.
  - L_CLR=R_CLR=1, so the latches are held cleared during reset.
  - COINC, xSINGLE and SCAL_VALID = 0; live counters and snapshots = 0.
- First edge after release: CLR outputs drop to 0.
- All outputs are registered.
- Event timing, with the first edge sampling SYNC[1]=1 as edge e:
  - State is OPEN after e.
  - A lone hit pulses xSINGLE after edge e+WINDOW, and xCLR is high after edges e+WINDOW .. e+WINDOW+CLR_LEN-1.
  - If the other polarisation is OPEN after edge f ≥ e with f ≤ e+WINDOW-1, COINC is high after edge f+1, and both CLRs start on that same edge.
- Simultaneous L and R entry (f=e): COINC after edge e+1.
- A hit from polarisation A while B is in CLEAR or WAIT opens only A's window; coincidence is impossible until B returns to OPEN.
- Reset asserted mid-window: outputs go to their reset values immediately and no pulse is emitted.

## Structure
- Shared package anita4_trig_pkg holds:
  - the state encoding (IDLE=0, OPEN=1, CLEAR=2, WAIT=3);
  - default constants for WINDOW, CLR_LEN and SCAL_W.
- Sub-module anita4_pol_win_fsm, instantiated twice, contains:
  - the FSM, win_cnt and CLR counter;
  - an OPEN status output and an other_open input;
  - hit/single event outputs.
- Top level holds the coincidence decision, the three saturating scalers and the snapshot register.

## Test plan
- Lone hit: L_SYNC[1]=1 at edge 10, WINDOW=4, CLR_LEN=2 -> L_SINGLE after edge 14; L_CLR high after edges 14–15; L_SCAL=1 and C_SCAL=0 at snapshot.
- Coincidence: L at edge 10, R at edge 12 -> COINC after edge 13; both CLRs high after edges 13–14; no SINGLE pulses; L=R=C=1.
- Window edge cases:
  - R at edge 13 -> COINC.
  - R at edge 14 -> L_SINGLE and a separate R window.
  - L and R both at edge 10 -> COINC after edge 11.
- Stuck latch: SYNC[1] held high 50 cycles -> exactly one hit counted; FSM stays in WAIT until SYNC[1]=0.
- Saturation and snapshot:
  - SCAL_W=4 with 20 hits -> L_SCAL=15.
  - SCAL_LATCH on the same edge as a new hit -> snapshot shows the old count; the live counter restarts at 1.
- Reset and disable:
  - RST_N low mid-OPEN -> CLRs=1 immediately; no COINC or SINGLE.
  - ENABLE=0 with a hit -> CLR pulse only; counters unchanged.
